// File: rtl/btb_pkg.sv
// Shared geometry defaults, entry view type and PC field helpers for the BTB.
// Entry fields are sized for the widest supported PC (BTB_MAX_W). Narrower
// geometries zero-extend into them.
package btb_pkg;
  localparam int BTB_ADDR_W = 32;
  localparam int BTB_SETS   = 256;
  localparam int BTB_WAYS   = 4;
  localparam int BTB_MAX_W  = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTB_MAX_W-1:0] tag;
    logic [BTB_MAX_W-1:0] target;
  } btb_entry_t;

  // The set index sits just above the ignored byte-offset bits pc[1:0].
  function automatic logic [BTB_MAX_W-1:0] pc_index(input logic [BTB_MAX_W-1:0] pc,
                                                    input int idx_w);
    return (pc >> 2) & ((BTB_MAX_W'(1) << idx_w) - BTB_MAX_W'(1));
  endfunction

  // The tag is every PC bit above the index.
  function automatic logic [BTB_MAX_W-1:0] pc_tag(input logic [BTB_MAX_W-1:0] pc,
                                                  input int idx_w);
    return pc >> (idx_w + 2);
  endfunction
endpackage

// File: rtl/btb_lru_set.sv
// True-LRU age vector for one BTB set. Age WAYS-1 marks the MRU way and age 0
// marks the LRU way. The ages always form a permutation of 0..WAYS-1.
// o_victim is the age-0 way. o_alloc is the lowest-numbered invalid way, and
// it is 0 when every way is valid.
module btb_lru_set
  import btb_pkg::*;
#(
  parameter  int WAYS  = BTB_WAYS,
  localparam int AGE_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_promote,
  input  logic [AGE_W-1:0] i_way,
  input  logic [WAYS-1:0]  i_valid,
  output logic [AGE_W-1:0] o_victim,
  output logic [AGE_W-1:0] o_alloc
);
  logic [WAYS-1:0][AGE_W-1:0] r_age;
  logic [AGE_W-1:0]           w_old;

  assign w_old = r_age[i_way];

  // Find the LRU way and the lowest free way.
  always_comb begin
    o_victim = '0;
    o_alloc  = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_age[w] == '0) o_victim = AGE_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!i_valid[w]) o_alloc = AGE_W'(w);
  end

  // Age update. A promoted way moves to MRU and the ways above its old age
  // shift down. A demoted way moves to LRU and the ways below its old age shift up.
  always_ff @(posedge clk) begin
    if (i_init) begin
      for (int w = 0; w < WAYS; w++) r_age[w] <= AGE_W'(w);
    end else if (i_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == i_way)
          r_age[w] <= i_promote ? AGE_W'(WAYS - 1) : '0;
        else if (i_promote && (r_age[w] > w_old))
          r_age[w] <= r_age[w] - AGE_W'(1);
        else if (!i_promote && (r_age[w] < w_old))
          r_age[w] <= r_age[w] + AGE_W'(1);
      end
    end
  end
endmodule

// File: rtl/branch_target_buffer.sv
// N-way set-associative branch target buffer with true-LRU replacement.
// Lookups are registered and return a result one cycle later. Updates from
// resolved branches train the buffer.
// Optional feature: defining BTB_BYPASS_EN forwards a same-cycle update with
// a matching PC into the lookup result. By default the lookup reads the
// state before the update.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter  int ADDR_W = BTB_ADDR_W,
  parameter  int SETS   = BTB_SETS,
  parameter  int WAYS   = BTB_WAYS,
  localparam int IDX_W  = $clog2(SETS),
  localparam int AGE_W  = $clog2(WAYS),
  localparam int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken
);
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [TAG_W-1:0]          r_tag [SETS][WAYS];
  logic [ADDR_W-1:0]         r_tgt [SETS][WAYS];
  logic                      r_pred_valid, r_pred_hit;
  logic [ADDR_W-1:0]         r_pred_tgt;

  logic [IDX_W-1:0]          w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]          w_lk_tag, w_up_tag;
  btb_entry_t                w_lk_ent [WAYS];
  logic                      w_lk_hit, w_up_hit, w_apply, w_lru_en;
  logic [ADDR_W-1:0]         w_lk_tgt;
  logic [AGE_W-1:0]          w_up_hitway, w_up_way;
  logic [SETS-1:0][AGE_W-1:0] w_victim, w_alloc;

  assign w_lk_idx = IDX_W'(pc_index(BTB_MAX_W'(lk_pc), IDX_W));
  assign w_lk_tag = TAG_W'(pc_tag(BTB_MAX_W'(lk_pc), IDX_W));
  assign w_up_idx = IDX_W'(pc_index(BTB_MAX_W'(upd_pc), IDX_W));
  assign w_up_tag = TAG_W'(pc_tag(BTB_MAX_W'(upd_pc), IDX_W));

  // Lookup: compare tags across the indexed set and select the hit target.
  // On a miss the target is the fall-through PC.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_tgt = lk_pc + ADDR_W'(4);
    for (int w = 0; w < WAYS; w++) begin
      w_lk_ent[w].valid  = r_valid[w_lk_idx][w];
      w_lk_ent[w].tag    = BTB_MAX_W'(r_tag[w_lk_idx][w]);
      w_lk_ent[w].target = BTB_MAX_W'(r_tgt[w_lk_idx][w]);
      if (w_lk_ent[w].valid && (w_lk_ent[w].tag == BTB_MAX_W'(w_lk_tag))) begin
        w_lk_hit = 1'b1;
        w_lk_tgt = ADDR_W'(w_lk_ent[w].target);
      end
    end
`ifdef BTB_BYPASS_EN
    // An update that flush drops must not be forwarded.
    if (upd_valid && !flush && (upd_pc == lk_pc)) begin
      w_lk_hit = upd_taken;
      w_lk_tgt = upd_taken ? upd_target : lk_pc + ADDR_W'(4);
    end
`endif
  end

  // Update decode: find the hit way and pick the way to write.
  // Allocation takes a free way first and the LRU way otherwise.
  always_comb begin
    w_up_hit    = 1'b0;
    w_up_hitway = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit    = 1'b1;
        w_up_hitway = AGE_W'(w);
      end
    if (upd_taken && !w_up_hit)
      w_up_way = (&r_valid[w_up_idx]) ? w_victim[w_up_idx] : w_alloc[w_up_idx];
    else
      w_up_way = w_up_hitway;
    w_apply  = upd_valid && !flush && !rst;
    w_lru_en = w_apply && (upd_taken || w_up_hit);
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_lru_set #(.WAYS(WAYS)) u_lru (
      .clk       (clk),
      .i_init    (rst || flush),
      .i_en      (w_lru_en && (w_up_idx == IDX_W'(s))),
      .i_promote (upd_taken),
      .i_way     (w_up_way),
      .i_valid   (r_valid[s]),
      .o_victim  (w_victim[s]),
      .o_alloc   (w_alloc[s])
    );
  end

  // Valid bits. Reset and flush clear every way in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush)
      r_valid <= '0;
    else if (upd_valid) begin
      if (upd_taken)     r_valid[w_up_idx][w_up_way]    <= 1'b1;
      else if (w_up_hit) r_valid[w_up_idx][w_up_hitway] <= 1'b0;
    end
  end

  // Tag and target storage. The valid bits gate these arrays, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_apply && upd_taken) begin
      r_tag[w_up_idx][w_up_way] <= w_up_tag;
      r_tgt[w_up_idx][w_up_way] <= upd_target;
    end
  end

  // Prediction registers. Hit and target hold their values when no lookup is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_pred_tgt   <= '0;
    end else begin
      r_pred_valid <= lk_valid;
      if (lk_valid) begin
        r_pred_hit <= w_lk_hit;
        r_pred_tgt <= w_lk_tgt;
      end
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_pred_hit;
  assign pred_target = r_pred_tgt;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios, then random traffic.
// A recency-list reference model supplies every expected value.
module tb_branch_target_buffer;
  localparam int SETS = 256;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst, flush, lk_valid, upd_valid, upd_taken;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        pred_valid, pred_hit;
  logic [31:0] pred_target;
  int          total = 0;
  int          bad   = 0;

  // Reference model: each set keeps a recency list, with index 0 = LRU.
  bit          m_v   [SETS][WAYS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ord [SETS][WAYS];
  bit          e_pv, e_ph;
  logic [31:0] e_pt;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  function automatic int m_find(logic [31:0] pc);
    int s;
    s = int'(pc[9:2]);
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && (m_tag[s][w] == {10'd0, pc[31:10]})) return w;
    return -1;
  endfunction

  task automatic m_reset_all();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w]   = 1'b0;
        m_ord[s][w] = w;
      end
  endtask

  task automatic m_touch(int s, int w, bit mru);
    int tmp[WAYS];
    int k;
    k = 0;
    if (!mru) begin tmp[0] = w; k = 1; end
    for (int i = 0; i < WAYS; i++)
      if (m_ord[s][i] != w) begin tmp[k] = m_ord[s][i]; k++; end
    if (mru) tmp[WAYS-1] = w;
    for (int i = 0; i < WAYS; i++) m_ord[s][i] = tmp[i];
  endtask

  task automatic m_update(logic [31:0] pc, logic [31:0] tgt, bit tk);
    int s, h, w;
    s = int'(pc[9:2]);
    h = m_find(pc);
    if (tk) begin
      if (h >= 0) w = h;
      else begin
        w = m_ord[s][0];
        for (int i = WAYS - 1; i >= 0; i--) if (!m_v[s][i]) w = i;
      end
      m_v[s][w]   = 1'b1;
      m_tag[s][w] = {10'd0, pc[31:10]};
      m_tgt[s][w] = tgt;
      m_touch(s, w, 1'b1);
    end else if (h >= 0) begin
      m_v[s][h] = 1'b0;
      m_touch(s, h, 1'b0);
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock with the currently driven inputs. Predicts the lookup from
  // the model state before the edge, then advances the model and checks.
  task automatic step();
    bit          hit;
    logic [31:0] tgt;
    int          w;
    hit = 1'b0;
    tgt = lk_pc + 32'd4;
    if (lk_valid) begin
      w = m_find(lk_pc);
      if (w >= 0) begin hit = 1'b1; tgt = m_tgt[int'(lk_pc[9:2])][w]; end
`ifdef BTB_BYPASS_EN
      if (upd_valid && !flush && (upd_pc == lk_pc)) begin
        hit = upd_taken;
        tgt = upd_taken ? upd_target : lk_pc + 32'd4;
      end
`endif
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset_all();
      e_pv = 1'b0; e_ph = 1'b0; e_pt = '0;
    end else begin
      e_pv = lk_valid;
      if (lk_valid) begin e_ph = hit; e_pt = tgt; end
      if (flush) m_reset_all();
      else if (upd_valid) m_update(upd_pc, upd_target, upd_taken);
    end
    check("pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
    check("pred_hit", {31'd0, pred_hit}, {31'd0, e_ph});
    check("pred_target", pred_target, e_pt);
  endtask

  task automatic drive(bit r, bit f, bit lv, logic [31:0] lp,
                       bit uv, logic [31:0] up, logic [31:0] ut, bit tk);
    rst = r; flush = f; lk_valid = lv; lk_pc = lp;
    upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
    step();
  endtask

  task automatic look(logic [31:0] pc);
    drive(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic train(logic [31:0] pc, logic [31:0] tgt, bit tk);
    drive(0, 0, 0, 0, 1, pc, tgt, tk);
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 2)
         | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] lp, up;
    m_reset_all();
    // 1: reset, then a cold lookup
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    look(32'h1000);
    check("t1_hit", {31'd0, pred_hit}, 32'd0);
    check("t1_target", pred_target, 32'h1004);
    // 2: train one branch, then hit it and miss on another tag in the same set
    train(32'h1000, 32'h2000, 1);
    look(32'h1000);
    check("t2_target", pred_target, 32'h2000);
    look(32'h1400);
    check("t2_miss_target", pred_target, 32'h1404);
    // 3: fill set 0, refresh 0x0000, then insert 0x1000, which evicts 0x0400
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    train(32'h0000, 32'hA000, 1);
    train(32'h0400, 32'hA400, 1);
    train(32'h0800, 32'hA800, 1);
    train(32'h0C00, 32'hAC00, 1);
    train(32'h0000, 32'hB000, 1);
    train(32'h1000, 32'hC000, 1);
    look(32'h0400); check("t3_evicted", {31'd0, pred_hit}, 32'd0);
    look(32'h0000); check("t3_kept", pred_target, 32'hB000);
    look(32'h1000); check("t3_new", pred_target, 32'hC000);
    // 4: a not-taken update frees a way, and the next allocation fills it
    train(32'h0800, 32'h0, 0);
    look(32'h0800); check("t4_cleared", {31'd0, pred_hit}, 32'd0);
    train(32'h1400, 32'hD000, 1);
    look(32'h0000); check("t4_keep0", {31'd0, pred_hit}, 32'd1);
    look(32'h0C00); check("t4_keepC", {31'd0, pred_hit}, 32'd1);
    look(32'h1000); check("t4_keep1", {31'd0, pred_hit}, 32'd1);
    look(32'h1400); check("t4_fill", pred_target, 32'hD000);
    // 5: same-cycle lookup and update, then a flush with a concurrent update
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h3000, 1, 32'h3000, 32'h4000, 1);
`ifdef BTB_BYPASS_EN
    check("t5_bypass_hit", {31'd0, pred_hit}, 32'd1);
    check("t5_bypass_tgt", pred_target, 32'h4000);
`else
    check("t5_rbw_hit", {31'd0, pred_hit}, 32'd0);
    check("t5_rbw_tgt", pred_target, 32'h3004);
`endif
    drive(0, 1, 1, 32'h3000, 1, 32'h5000, 32'h6000, 1);
    check("t5_flush_cycle_hit", {31'd0, pred_hit}, 32'd1);
    look(32'h3000); check("t5_after_flush", {31'd0, pred_hit}, 32'd0);
    look(32'h5000); check("t5_dropped_upd", {31'd0, pred_hit}, 32'd0);
    // 6: reset during a lookup, then the PC + 4 wrap-around
    train(32'h6000, 32'h7000, 1);
    drive(1, 0, 1, 32'h6000, 0, 0, 0, 0);
    check("t6_rst_pv", {31'd0, pred_valid}, 32'd0);
    look(32'h6000); check("t6_invalid", {31'd0, pred_hit}, 32'd0);
    look(32'hFFFF_FFFC); check("t6_wrap", pred_target, 32'h0000_0000);
    // Random traffic over a few sets and tags, so sets stay contended
    for (int i = 0; i < 3000; i++) begin
      lp = rpc();
      up = ($urandom_range(0, 3) == 0) ? lp : rpc();
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7, lp, $urandom_range(0, 1) == 1, up,
            $urandom, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
